mux_sel_sequencer: RTL
======================

// Module: mux_sel_sequencer
// PURPOSE
//  Upstream feeder for the registered 8:1 mux (mux8to1). Accepts parallel words over a valid/ready
//  handshake and presents each word stable on mux_data. Walks mux_sel through every index, one per clk,
//  so the mux serialises the word. Has a one-entry holding buffer, so back-to-back words stream with no bubble.
// PARAMETERS
//  DATA_W     8  word width; power of two, >=2; SEL_W = $clog2(DATA_W)
//  MSB_FIRST  0  0: sel walks 0..DATA_W-1; 1: sel walks DATA_W-1..0
//  GAP_CYCLES 0  idle cycles (mux_en=0) inserted after each word; 0..15
// PORTS
//  clk         in   1       rising-edge clock
//  rst         in   1       asynchronous, active-high reset
//  in_valid    in   1       upstream word valid
//  in_data     in   DATA_W  upstream word
//  in_ready    out  1       sequencer can accept a word this cycle
//  mux_data    out  DATA_W  word driven to the mux data input; stable for the whole scan
//  mux_sel     out  SEL_W   mux select
//  mux_en      out  1       mux_sel is a live scan index this cycle
//  word_start  out  1       1-cycle pulse: first index of a word is on mux_sel
//  word_done   out  1       1-cycle pulse: last index of a word is on mux_sel
//  busy        out  1       state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, hold empty. mux_data, mux_sel, mux_en, word_start, word_done and busy are all 0.
//   in_ready is 0 while rst=1 and 1 from the first cycle after deassertion.
//  Handshake: transfer on the rising edge when in_valid&&in_ready. in_ready = !hold_full, taken from a register.
//   Upstream may drop in_valid or change in_data freely while in_ready=0.
//  FSM: IDLE, SCAN, GAP.
//   IDLE: a transfer loads the active register and mux_data directly. mux_sel = first index.
//    Next cycle: SCAN, mux_en=1, word_start=1. Accept-to-first-mux_en latency is 1 clk.
//   SCAN: mux_en=1. mux_sel steps by +1 (or -1 if MSB_FIRST) each clk.
//    A transfer in SCAN goes to the hold register.
//    Last index (DATA_W-1, or 0 if MSB_FIRST): word_done=1. At that edge:
//     GAP_CYCLES>0             -> GAP, counter loaded to GAP_CYCLES.
//     else hold_full or transfer -> reload active from hold (or from in_data if hold is empty),
//                                   first index, word_start next cycle, stay in SCAN.
//     else                     -> IDLE; mux_sel=0 and mux_en=0, while mux_data keeps the last word.
//   GAP: mux_en=0. Counter decrements. At count 1, apply the same reload-or-IDLE rule as end of SCAN.
//  Simultaneous events:
//   Transfer on the same edge as hold->active reload: the new word enters hold, with no loss and no duplicate.
//   Transfer on the last-index edge with hold empty: the word bypasses straight to active.
//  Sustained rate at GAP_CYCLES=0 is one word per DATA_W clks, and mux_en stays 1 continuously.
//  mux8to1 registers its output, so the serial bit for mux_sel at cycle n appears at cycle n+1.
//   A downstream consumer delays mux_en/word_done by 1 clk to stay aligned.
//  Reset mid-scan aborts immediately. Active and hold words are discarded, and word_done is not pulsed.
//  The sel counter is SEL_W bits wide and never wraps silently. Terminal index is an explicit compare.
// STRUCTURE
//  Shared package mux_seq_pkg holds:
//   - state encoding typedef (IDLE=2'd0, SCAN=2'd1, GAP=2'd2)
//   - localparam function sel_w(DATA_W)
//   - GAP_CYCLES range constant
//  One sub-module: mux_hold_reg, a one-entry DATA_W buffer with full flag, load, and unload.
//   It owns hold_full and in_ready.
//  Top module holds the FSM, the sel/gap counters and the active register.
// TESTING (bench instantiates mux8to1 downstream; checker samples on posedge, driver on negedge)
//  1 Reset, then single word 8'hA5, LSB-first:
//    mux_sel 0..7 on 8 consecutive clks, mux_en=1; mux out 1,0,1,0,0,1,0,1 one clk later.
//    word_start on sel=0, word_done on sel=7, then IDLE and busy=0.
//  2 MSB_FIRST=1, word 8'h81: sel 7..0; mux out 1,0,0,0,0,0,0,1.
//  3 in_valid held high with 8'h01, 8'h02, 8'h03, GAP=0:
//    24 continuous mux_en clks with no bubble. in_ready=0 while hold is full.
//    All three words are serialised in order.
//  4 GAP_CYCLES=3, two words: exactly 3 clks of mux_en=0 between word_done and the next word_start.
//  5 Transfer on the last-index edge with hold empty: the next word_start follows immediately (bypass).
//  6 rst asserted at sel=4 of 8'hFF with a second word held:
//    all outputs 0 asynchronously, no word_done, busy=0.
//    After release, the next accepted word 8'h3C scans correctly from sel=0.

Source files
------------

// File: rtl/mux_seq_pkg.sv
// ---------------------------------------------------------------------------
// mux_seq_pkg
//   Shared definitions for the mux select sequencer: FSM state encoding,
//   select-width helper and the GAP_CYCLES range limits.
// ---------------------------------------------------------------------------
package mux_seq_pkg;

    // State encoding kept as fixed constants so existing decoders and
    // waveform filters keyed on the raw 2-bit values keep working.
    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t SCAN = 2'd1;
    localparam state_t GAP  = 2'd2;

    // Inter-word idle gap: 0..GAP_CYCLES_MAX cycles, counted in GAP_CNT_W bits.
    localparam int unsigned GAP_CYCLES_MAX = 15;
    localparam int unsigned GAP_CNT_W      = 4;

    // Select width for a DATA_W-input mux.
    function automatic int unsigned sel_w(input int unsigned data_w);
        return $clog2(data_w);
    endfunction

endpackage

// File: rtl/mux_hold_reg.sv
// ---------------------------------------------------------------------------
// mux_hold_reg
//   One-entry DATA_W holding buffer for the sequencer. Owns the full flag
//   and the registered upstream ready.
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   load       in   capture load_data (word arriving while active is busy)
//   load_data  in   word to capture
//   unload     in   held word is being moved to the active register
//   hold_data  out  held word
//   hold_full  out  buffer occupied
//   in_ready   out  registered !hold_full; 0 during reset
// ---------------------------------------------------------------------------
module mux_hold_reg #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              unload,
    output logic [DATA_W-1:0] hold_data,
    output logic              hold_full,
    output logic              in_ready
);

    logic full_next;

    // Load wins over unload: a word arriving on the unload edge refills the slot.
    always_comb begin
        full_next = hold_full;
        if (unload) full_next = 1'b0;
        if (load)   full_next = 1'b1;
    end

    // in_ready is computed from the next full state so it is a plain flop
    // output yet still tracks hold_full cycle-for-cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_full <= 1'b0;
            in_ready  <= 1'b0;
            hold_data <= '0;
        end else begin
            hold_full <= full_next;
            in_ready  <= !full_next;
            if (load) hold_data <= load_data;
        end
    end

endmodule

// File: rtl/mux_sel_sequencer.sv
// ---------------------------------------------------------------------------
// mux_sel_sequencer
//   Feeds a registered DATA_W:1 mux. Accepts words over valid/ready, holds
//   each word stable on mux_data and walks mux_sel through every index, one
//   per clock, so the mux serialises the word. A one-entry hold buffer lets
//   back-to-back words stream without a bubble.
// Parameters
//   DATA_W      word width (power of two, >= 2)
//   MSB_FIRST   0: sel walks 0..DATA_W-1, 1: sel walks DATA_W-1..0
//   GAP_CYCLES  idle cycles (mux_en=0) after each word, 0..15
// Ports
//   clk, rst    clock / asynchronous active-high reset
//   in_valid    upstream word valid
//   in_data     upstream word
//   in_ready    sequencer can accept a word this cycle
//   mux_data    word presented to the mux, stable for the whole scan
//   mux_sel     mux select
//   mux_en      mux_sel is a live scan index
//   word_start  first index of a word is on mux_sel
//   word_done   last index of a word is on mux_sel
//   busy        state != IDLE
// ---------------------------------------------------------------------------
module mux_sel_sequencer
    import mux_seq_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter bit          MSB_FIRST  = 1'b0,
    parameter int unsigned GAP_CYCLES = 0,
    localparam int unsigned SEL_W     = sel_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [DATA_W-1:0] mux_data,
    output logic [SEL_W-1:0]  mux_sel,
    output logic              mux_en,
    output logic              word_start,
    output logic              word_done,
    output logic              busy
);

    localparam logic [SEL_W-1:0]     FIRST_IDX = MSB_FIRST ? SEL_W'(DATA_W - 1) : '0;
    localparam logic [SEL_W-1:0]     LAST_IDX  = MSB_FIRST ? '0 : SEL_W'(DATA_W - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LOAD  = GAP_CNT_W'(GAP_CYCLES);

    state_t               state;
    logic [SEL_W-1:0]     sel;
    logic [GAP_CNT_W-1:0] gap_cnt;
    logic [DATA_W-1:0]    active;

    logic              xfer;
    logic              at_last;
    logic              end_to_gap;
    logic              reload_pt;
    logic              take_hold;
    logic              bypass;
    logic              idle_take;
    logic              hold_load;
    logic              hold_unload;
    logic [DATA_W-1:0] hold_data;
    logic              hold_full;

    assign xfer    = in_valid && in_ready;
    assign at_last = (state == SCAN) && (sel == LAST_IDX);

    // Word boundary: either the last scan index (no gap) or the final gap
    // cycle. Both apply the same reload-or-idle rule below.
    assign end_to_gap = at_last && (GAP_CYCLES != 0);
    assign reload_pt  = (at_last && (GAP_CYCLES == 0)) ||
                        ((state == GAP) && (gap_cnt == GAP_CNT_W'(1)));

    // Held word takes priority; with an empty hold a word arriving on the
    // boundary edge goes straight to active. Any other accepted word that is
    // not the IDLE pickup lands in hold.
    assign take_hold   = reload_pt && hold_full;
    assign bypass      = reload_pt && !hold_full && xfer;
    assign idle_take   = (state == IDLE) && xfer;
    assign hold_load   = xfer && !bypass && !idle_take;
    assign hold_unload = take_hold;

    mux_hold_reg #(
        .DATA_W(DATA_W)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .load      (hold_load),
        .load_data (in_data),
        .unload    (hold_unload),
        .hold_data (hold_data),
        .hold_full (hold_full),
        .in_ready  (in_ready)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sel     <= '0;
            gap_cnt <= '0;
            active  <= '0;
        end else if (reload_pt) begin
            if (take_hold) begin
                active <= hold_data;
                sel    <= FIRST_IDX;
                state  <= SCAN;
            end else if (bypass) begin
                active <= in_data;
                sel    <= FIRST_IDX;
                state  <= SCAN;
            end else begin
                sel    <= '0;
                state  <= IDLE;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        active <= in_data;
                        sel    <= FIRST_IDX;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (end_to_gap) begin
                        gap_cnt <= GAP_LOAD;
                        sel     <= '0;
                        state   <= GAP;
                    end else if (MSB_FIRST) begin
                        sel <= sel - 1'b1;
                    end else begin
                        sel <= sel + 1'b1;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt - 1'b1;
                end
                default: begin
                    sel   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign mux_data   = active;
    assign mux_sel    = sel;
    assign mux_en     = (state == SCAN);
    assign word_start = mux_en && (sel == FIRST_IDX);
    assign word_done  = mux_en && (sel == LAST_IDX);
    assign busy       = (state != IDLE);

endmodule
